// File: rtl/ps2_pkg.sv
// Shared PS/2 scancodes, frame-receiver state encoding and the digit lookup
// used by the keyboard number-entry front end.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_D0    = 8'h45;
    localparam logic [7:0] SC_D1    = 8'h16;
    localparam logic [7:0] SC_D2    = 8'h1E;
    localparam logic [7:0] SC_D3    = 8'h26;
    localparam logic [7:0] SC_D4    = 8'h25;
    localparam logic [7:0] SC_D5    = 8'h2E;
    localparam logic [7:0] SC_D6    = 8'h36;
    localparam logic [7:0] SC_D7    = 8'h3D;
    localparam logic [7:0] SC_D8    = 8'h3E;
    localparam logic [7:0] SC_D9    = 8'h46;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] val;
    } digit_t;

    // Map a make-code to its decimal digit; hit=0 for non-digit codes.
    function automatic digit_t sc_to_digit(input logic [7:0] sc);
        digit_t d;
        d.hit = 1'b1;
        d.val = 4'd0;
        case (sc)
            SC_D0:   d.val = 4'd0;
            SC_D1:   d.val = 4'd1;
            SC_D2:   d.val = 4'd2;
            SC_D3:   d.val = 4'd3;
            SC_D4:   d.val = 4'd4;
            SC_D5:   d.val = 4'd5;
            SC_D6:   d.val = 4'd6;
            SC_D7:   d.val = 4'd7;
            SC_D8:   d.val = 4'd8;
            SC_D9:   d.val = 4'd9;
            default: d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises the kbd lines, samples on
// falling kbd_clk, checks start/odd-parity/stop and aborts stalled frames.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_kbd_clk,
    input  logic       i_kbd_data,
    output logic [7:0] o_byte,
    output logic       o_byte_stb,
    output logic       o_err_stb
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic          r_clk_s1, r_clk_s2, r_clk_s3;
    logic          r_dat_s1, r_dat_s2;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_tmo_cnt;
    logic          w_fall;
    logic          w_timeout;
    logic          w_byte_ok;
    logic          w_err;

    assign w_fall    = r_clk_s3 & ~r_clk_s2;
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Two-flop synchronisers plus one extra kbd_clk stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_kbd_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= i_kbd_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_ok   = 1'b0;
        w_err       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_err       = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (r_dat_s2) w_err       = 1'b1;
                    else          w_state_nxt = DATA;
                end
                DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY: w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    if (r_dat_s2 && r_par_ok) w_byte_ok = 1'b1;
                    else                      w_err     = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Shift register, parity capture, inactivity counter and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_par_ok   <= 1'b0;
            r_tmo_cnt  <= '0;
            o_byte     <= 8'd0;
            o_byte_stb <= 1'b0;
            o_err_stb  <= 1'b0;
        end else begin
            if (w_fall) begin
                case (r_state)
                    IDLE:   r_bit_cnt <= 3'd0;
                    DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    PARITY: r_par_ok <= ^{r_dat_s2, r_shift};
                    default: ;
                endcase
            end
            if (r_state == IDLE || w_fall) r_tmo_cnt <= '0;
            else                           r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_byte_ok) o_byte <= r_shift;
            o_byte_stb <= w_byte_ok;
            o_err_stb  <= w_err;
        end
    end

endmodule

// File: rtl/ps2_number_input.sv
// Keyboard number entry for the CPU IN instruction: decodes digit/Enter/Backspace
// make-codes into a saturating decimal accumulator and queues committed numbers.
module ps2_number_input
    import ps2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          kbd_clk,
    input  logic                          kbd_data,
    input  logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int unsigned AW = DATA_WIDTH + 4;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]            w_byte;
    logic                  w_byte_stb;
    logic                  w_err_stb;
    digit_t                w_dig;
    logic [AW-1:0]         w_prod;
    logic [DATA_WIDTH-1:0] w_acc_inc;
    logic [DATA_WIDTH-1:0] w_acc_nxt;
    logic                  w_brk_nxt, w_ext_nxt;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_brk, r_ext;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr, r_rd, w_rd_nxt;
    logic [CW-1:0]         r_count, w_cnt_nxt, w_remain;
    logic [DATA_WIDTH-1:0] r_head, w_head_nxt;
    logic                  r_valid, r_ovf;
    logic                  w_full, w_pop, w_wr, w_ovf_set;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_kbd_clk  (kbd_clk),
        .i_kbd_data (kbd_data),
        .o_byte     (w_byte),
        .o_byte_stb (w_byte_stb),
        .o_err_stb  (w_err_stb)
    );

    // Accumulate at widened precision, clamp to all-ones on overflow.
    assign w_dig     = sc_to_digit(w_byte);
    assign w_prod    = AW'(r_acc) * AW'(10) + AW'(w_dig.val);
    assign w_acc_inc = (w_prod > AW'({DATA_WIDTH{1'b1}})) ? {DATA_WIDTH{1'b1}}
                                                          : w_prod[DATA_WIDTH-1:0];

    // A pending break or extended prefix swallows the following byte.
    always_comb begin
        w_acc_nxt = r_acc;
        w_brk_nxt = r_brk;
        w_ext_nxt = r_ext;
        w_push    = 1'b0;
        if (w_byte_stb) begin
            if (r_brk)                    w_brk_nxt = 1'b0;
            else if (r_ext)               w_ext_nxt = 1'b0;
            else if (w_byte == SC_BREAK)  w_brk_nxt = 1'b1;
            else if (w_byte == SC_EXT)    w_ext_nxt = 1'b1;
            else if (w_dig.hit)           w_acc_nxt = w_acc_inc;
            else if (w_byte == SC_ENTER) begin
                w_push    = 1'b1;
                w_acc_nxt = '0;
            end else if (w_byte == SC_BKSP) w_acc_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_brk <= w_brk_nxt;
            r_ext <= w_ext_nxt;
        end
    end

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = in_ready & r_valid;
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;
    assign w_cnt_nxt = r_count + CW'(w_wr) - CW'(w_pop);
    assign w_remain  = r_count - CW'(w_pop);
    assign w_rd_nxt  = r_rd + PW'(w_pop);

    // Head register: bypass the pushed word when it lands in an otherwise empty queue.
    always_comb begin
        w_head_nxt = r_mem[w_rd_nxt];
        if (w_remain == '0) w_head_nxt = w_wr ? r_acc : r_head;
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= r_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) r_wr <= r_wr + PW'(1);
            r_rd    <= w_rd_nxt;
            r_count <= w_cnt_nxt;
            r_head  <= w_head_nxt;
            r_valid <= (w_cnt_nxt != '0);
            if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    assign in_data    = r_head;
    assign in_valid   = r_valid;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
    assign frame_err  = w_err_stb;

endmodule
